// File: rtl/cla_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_seq_ctrl_if
//  Description : Operand/result handshake bundle for the nibble-serial
//                add/subtract controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cla_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cla_seq_ctrl (+ carryadder 4-bit CLA slice)
//  Description : WIDTH-bit add/subtract computed one nibble per clock, LSB
//                first, through a single time-shared carry-lookahead slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module carryadder (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    output logic      [3:0] s,
    output logic            cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ w_c;
endmodule

module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cla_seq_ctrl_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_s;
    logic             w_nib_cout;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last;

    assign w_accept = w_in_ready & bus.in_valid;
    assign w_last   = (r_idx == C_LAST_IDX);

    // Nibble select written as a compare-per-slot mux so every index width is exact.
    always_comb begin
        w_nib_a = '0;
        w_nib_b = '0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_nib_a = r_opa[4*n +: 4];
                w_nib_b = r_opb[4*n +: 4];
            end
        end
    end

    carryadder u_slice (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .s    (w_nib_s),
        .cout (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted on entry and the +1 rides in as the first carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_opa   <= bus.op_a;
            r_opb   <= bus.sub ? ~bus.op_b : bus.op_b;
            r_carry <= bus.sub;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == S_RUN) begin
            for (int n = 0; n < NIB; n++) begin
                if (r_idx == IDXW'(n)) begin
                    r_sum[4*n +: 4] <= w_nib_s;
                end
            end
            r_carry <= w_nib_cout;
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
    // Operands share a sign yet the result sign differs: signed overflow.
    assign bus.ovf       = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                           (r_sum[WIDTH-1] != r_opa[WIDTH-1]);
endmodule
`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_seq_ctrl
//  Description : Vector table and corner sequences at WIDTH=16, plus random
//                operations at WIDTH=4/16/32 against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_seq_ctrl;
    logic   clk   = 1'b0;
    logic   rst_d = 1'b1;
    logic   rst_r = 1'b1;
    longint cyc   = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular and signed arithmetic on the full operands.
    function automatic void ref_op(input int w, input longint a, input longint b, input bit s,
                                   output longint sum, output bit co, output bit ov);
        longint m;
        longint sa;
        longint sb;
        longint r;
        m   = longint'(1) << w;
        sum = s ? (a - b) : (a + b);
        sum = ((sum % m) + m) % m;
        co  = s ? (a >= b) : ((a + b) >= m);
        sa  = (a >= m / 2) ? a - m : a;
        sb  = (b >= m / 2) ? b - m : b;
        r   = s ? sa - sb : sa + sb;
        ov  = (r >= m / 2) || (r < -(m / 2));
    endfunction

    // ---------------- directed DUT, WIDTH=16 ----------------
    cla_seq_ctrl_if #(.WIDTH(16)) bd ();
    cla_seq_ctrl #(.WIDTH(16)) dut (.clk(clk), .rst(rst_d), .bus(bd.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        bd.op_a = v.a; bd.op_b = v.b; bd.sub = v.s; bd.in_valid = 1'b1;
        @(negedge clk);
        bd.in_valid = 1'b0;
        check({tag, "_busy"}, 64'(bd.busy), 64'd1);
        lat = 0;
        while (!bd.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"},  64'(bd.sum),  64'(v.sum));
        check({tag, "_cout"}, 64'(bd.cout), 64'(v.co));
        check({tag, "_ovf"},  64'(bd.ovf),  64'(v.ov));
        bd.out_ready = 1'b1;
        @(negedge clk);
        bd.out_ready = 1'b0;
        check({tag, "_in_ready_after"},  64'(bd.in_ready),  64'd1);
        check({tag, "_out_valid_after"}, 64'(bd.out_valid), 64'd0);
    endtask

    // ---------------- random DUTs at three widths ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int W = (g == 0) ? 4 : ((g == 1) ? 16 : 32);
        localparam int N = W / 4;
        cla_seq_ctrl_if #(.WIDTH(W)) br ();
        cla_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst_r), .bus(br.slave));
        bit done_f = 1'b0;

        initial begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         s;
            longint       es;
            bit           eco;
            bit           eov;
            int           lat;
            int           guard;
            longint       rise;
            longint       last_rise;
            br.in_valid = 1'b0; br.out_ready = 1'b0;
            br.op_a = '0; br.op_b = '0; br.sub = 1'b0;
            last_rise = 0;
            @(negedge clk);
            while (rst_r) @(negedge clk);
            for (int k = 0; k < 1000; k++) begin
                if ($urandom % 4 == 0) begin
                    br.in_valid = 1'b0;
                    @(negedge clk);
                end
                a = W'($urandom); b = W'($urandom); s = 1'($urandom % 2);
                ref_op(W, longint'(a), longint'(b), s, es, eco, eov);
                br.op_a = a; br.op_b = b; br.sub = s; br.in_valid = 1'b1;
                check($sformatf("w%0d_in_ready", W), 64'(br.in_ready), 64'd1);
                @(negedge clk);
                lat = 0;
                while (!br.out_valid && lat <= N + 4) begin
                    check($sformatf("w%0d_run_in_ready", W), 64'(br.in_ready), 64'd0);
                    br.in_valid  = 1'($urandom % 2);
                    br.op_a      = W'($urandom);
                    br.out_ready = 1'($urandom % 2);
                    @(negedge clk);
                    lat++;
                end
                rise = cyc;
                check($sformatf("w%0d_latency", W), 64'(lat), 64'(N));
                if (k > 0) begin
                    check($sformatf("w%0d_spacing_ok", W), 64'(rise - last_rise >= N + 2), 64'd1);
                end
                last_rise = rise;
                guard = 0;
                while (br.out_valid && guard < 50) begin
                    check($sformatf("w%0d_sum", W),  64'(br.sum),  64'(es));
                    check($sformatf("w%0d_cout", W), 64'(br.cout), 64'(eco));
                    check($sformatf("w%0d_ovf", W),  64'(br.ovf),  64'(eov));
                    br.out_ready = 1'(($urandom % 3) != 0);
                    br.in_valid  = 1'($urandom % 2);
                    br.op_b      = W'($urandom);
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 50) begin
                    check($sformatf("w%0d_handshake_timeout", W), 64'd0, 64'd1);
                    break;
                end
                br.out_ready = 1'b0;
            end
            br.in_valid = 1'b0;
            done_f = 1'b1;
        end
    end

    initial begin
        vec_t   tbl[7];
        logic [15:0] h_sum;
        logic   h_co;
        logic   h_ov;
        int     t;

        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        bd.in_valid = 1'b0; bd.out_ready = 1'b0;
        bd.op_a = '0; bd.op_b = '0; bd.sub = 1'b0;
        repeat (3) @(negedge clk);
        rst_d = 1'b0;
        rst_r = 1'b0;
        check("rst_in_ready",  64'(bd.in_ready),  64'd1);
        check("rst_out_valid", 64'(bd.out_valid), 64'd0);
        check("rst_busy",      64'(bd.busy),      64'd0);
        check("rst_sum",       64'(bd.sum),       64'd0);
        check("rst_cout",      64'(bd.cout),      64'd0);
        check("rst_ovf",       64'(bd.ovf),       64'd0);

        for (int i = 0; i < 7; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles with stray in_valid pulses.
        bd.op_a = 16'h1234; bd.op_b = 16'h0FCD; bd.sub = 1'b0; bd.in_valid = 1'b1;
        @(negedge clk);
        bd.in_valid = 1'b0;
        t = 0;
        while (!bd.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_latency", 64'(t), 64'd4);
        h_sum = bd.sum; h_co = bd.cout; h_ov = bd.ovf;
        for (int i = 0; i < 10; i++) begin
            bd.in_valid = 1'($urandom % 2);
            bd.op_a = 16'($urandom); bd.op_b = 16'($urandom); bd.sub = 1'($urandom % 2);
            @(negedge clk);
            check("bp_out_valid", 64'(bd.out_valid), 64'd1);
            check("bp_in_ready",  64'(bd.in_ready),  64'd0);
            check("bp_sum",  64'(bd.sum),  64'h2201);
            check("bp_hold", 64'({bd.sum, bd.cout, bd.ovf}), 64'({h_sum, h_co, h_ov}));
        end
        bd.in_valid = 1'b0;
        bd.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready",  64'(bd.in_ready),  64'd1);
        check("bp_release_out_valid", 64'(bd.out_valid), 64'd0);
        @(negedge clk);
        check("bp_single_handshake", 64'(bd.out_valid), 64'd0);
        bd.out_ready = 1'b0;

        // Reset while RUN is on nibble 2.
        bd.op_a = 16'hFFFF; bd.op_b = 16'hFFFF; bd.sub = 1'b1; bd.in_valid = 1'b1;
        @(negedge clk);
        bd.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        check("midrst_in_ready",  64'(bd.in_ready),  64'd1);
        check("midrst_out_valid", 64'(bd.out_valid), 64'd0);
        check("midrst_busy",      64'(bd.busy),      64'd0);
        check("midrst_sum",       64'(bd.sum),       64'd0);
        check("midrst_cout",      64'(bd.cout),      64'd0);
        apply_vec('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0}, "post_rst");

        t = 0;
        while (!(g_rand[0].done_f && g_rand[1].done_f && g_rand[2].done_f) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60000) begin
            check("random_timeout", 64'd0, 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cla_seq_ctrl.md
# cla_seq_ctrl

Sequencing controller that performs WIDTH-bit add/subtract by time-sharing a single 4-bit carry-lookahead slice, one nibble per clock, LSB first. The nibble carry-out is registered and fed back as the next nibble's carry-in. Operands enter through a valid/ready handshake and results leave through one. The block sits between operand-issuing logic and any consumer that needs wide sums but cannot afford WIDTH/4 parallel slices.

## Interface

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4. NIB = WIDTH/4 is the nibble count.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept an operand set
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B (A + ~B + 1)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  two's-complement signed overflow
- busy  out  1  high in RUN and DONE

## Operation

- Datapath: one 4-bit CLA slice with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout. The slice must compute s + 16*cout = a + b + cin. The carryadder module satisfies this and is the intended instance.
- Registers:
  - opa_r, opb_r (WIDTH each); opb_r holds ~op_b when sub=1.
  - carry_r (1): initialised to sub on accept.
  - idx (ceil(log2(NIB)) bits, min 1).
  - sum_r (WIDTH).
  - state.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch operands, carry_r<=sub, idx<=0, sum_r<=0, go to RUN.
  - RUN: each cycle, feed slice with opa_r[4*idx+:4], opb_r[4*idx+:4], carry_r. Write s to sum_r[4*idx+:4] and slice cout to carry_r. If idx==NIB-1, go to DONE; otherwise idx<=idx+1.
  - DONE: out_valid=1. sum=sum_r, cout=carry_r. ovf=(opa_r[MSB]==opb_r[MSB])&&(sum_r[MSB]!=opa_r[MSB]). On out_ready, go to IDLE.
- in_ready is combinationally (state==IDLE). in_valid is ignored in RUN and DONE.
- Outputs in DONE are held stable until out_ready is sampled high.
- sum/cout/ovf are don't-care when out_valid=0, but they must not glitch while out_valid=1.
- busy is combinationally (state!=IDLE).
- Reset:
  - state<=IDLE; out_valid=0, in_ready=1 in the first post-reset cycle.
  - sum_r, carry_r, idx, opa_r, opb_r <= 0, so sum=0, cout=0, ovf=0.
  - Reset in RUN or DONE aborts the operation; no result is emitted.
  - Reset dominates any simultaneous handshake.
- WIDTH=4 (NIB=1): RUN lasts exactly one cycle.

## Timing

- Accept edge E0 (in_valid&&in_ready high at E0). RUN occupies the NIB cycles following E0.
- out_valid rises after edge E0+NIB, i.e. NIB cycles after the accept. For WIDTH=16, that is 4 cycles.
- Result handshake at edge Ek (out_valid&&out_ready): state is IDLE after Ek and in_ready=1 in the next cycle.
- Earliest next accept is edge Ek+1.
- Maximum throughput: one operation per NIB+2 cycles.
- out_ready held low: DONE persists indefinitely with all outputs constant.
- out_ready high during RUN has no effect.
- Critical path: nibble mux, then one CLA slice, then carry_r. There is no combinational path from in_valid or out_ready to sum.

## Test plan

- Add, WIDTH=16: A=0x1234, B=0x0FCD, sub=0 -> sum=0x2201, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Carry ripple across all nibbles: A=0xFFFF, B=0x0001 -> sum=0x0000, cout=1, ovf=0. Also A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Outputs stay constant, in_ready stays 0, and in_valid pulses are ignored.
  - Raising out_ready gives exactly one handshake, then in_ready=1 the next cycle.
- Reset mid-operation: assert rst for one cycle at RUN idx=2.
  - Next cycle: state IDLE, out_valid=0, in_ready=1, sum=0.
  - A following operation 0x00FF+0x0001 yields 0x0100 with no stale carry.
- Back-to-back plus random: 1000 random A/B/sub operations with random out_ready.
  - Results match the arithmetic reference model.
  - Spacing between results is never under NIB+2 cycles.
  - Repeat at WIDTH=4 and WIDTH=32.
